// File: rtl/compare_input_debounce_if.sv
// Switch-side inputs and comparator-side outputs of the operand conditioner.
interface compare_input_debounce_if;
  logic [1:0] sw_a;
  logic [1:0] sw_b;
  logic       hold;
  logic [1:0] a;
  logic [1:0] b;
  logic       upd;

  modport master (output sw_a, sw_b, hold, input a, b, upd);
  modport slave  (input sw_a, sw_b, hold, output a, b, upd);
endinterface

// File: rtl/compare_input_debounce.sv
// Operand conditioner for the 2-bit comparator: per-bit 2-flop sync and
// debounce, then a holdable output register with a one-cycle update strobe.
module compare_input_debounce_bit #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stab
);
  logic             s1, s2;
  logic [CNT_W-1:0] cnt;

  // Any cycle that agrees with the stable value restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      stab <= 1'b0;
      cnt  <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == stab) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
        stab <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

module compare_input_debounce #(
  parameter int STABLE_CYCLES = 240000
) (
  input  logic                    clk,
  input  logic                    rst,
  compare_input_debounce_if.slave bus
);
  localparam int CNT_W     = $clog2(STABLE_CYCLES);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0] raw, stab, ab_q;
  logic                 upd_q;

  // Lane order {a[1], a[0], b[1], b[0]} keeps bit positions straight through.
  assign raw = {bus.sw_a, bus.sw_b};

  compare_input_debounce_bit #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_bit [NUM_LANES-1:0] (
    .clk (clk),
    .rst (rst),
    .raw (raw),
    .stab(stab)
  );

  // A single compare over all lanes gives one strobe for simultaneous flips.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ab_q  <= '0;
      upd_q <= 1'b0;
    end else if (!bus.hold) begin
      ab_q  <= stab;
      upd_q <= (stab != ab_q);
    end else begin
      upd_q <= 1'b0;
    end
  end

  assign bus.a   = ab_q[3:2];
  assign bus.b   = ab_q[1:0];
  assign bus.upd = upd_q;
endmodule
